// File: rtl/rf_write_queue_pkg.sv
// Shared defaults and width helpers for the register-file write queue.
// Pulled in by the queue top and its lookup selector.
package rf_write_queue_pkg;

  localparam int RWQ_DEPTH  = 4;
  localparam int RWQ_DATA_W = 16;
  localparam int RWQ_REG_W  = 3;

  // Pointer width for a power-of-two depth; the count is one bit wider.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int RWQ_PTR_W = ptr_width(RWQ_DEPTH);

endpackage

// File: rtl/rf_wq_lookup.sv
// Youngest-match selector over the queue entries.
// Scans from head (oldest) to tail (youngest), so the last match wins.
module rf_wq_lookup
  import rf_write_queue_pkg::*;
#(
  parameter int DEPTH  = RWQ_DEPTH,
  parameter int DATA_W = RWQ_DATA_W,
  parameter int REG_W  = RWQ_REG_W,
  parameter int PTR_W  = ptr_width(DEPTH)
) (
  input  logic [DEPTH-1:0]        valid,
  input  logic [DEPTH*REG_W-1:0]  regsel_flat,
  input  logic [DEPTH*DATA_W-1:0] data_flat,
  input  logic [PTR_W-1:0]        head,
  input  logic [REG_W-1:0]        sel,
  output logic                    hit,
  output logic [DATA_W-1:0]       data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && (regsel_flat[idx*REG_W +: REG_W] == sel)) begin
        hit  = 1'b1;
        data = data_flat[idx*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/rf_write_queue.sv
// Write queue in front of the bypassing register file: buffers writebacks,
// retires one per cycle, and exposes pending bits plus two forwarding lookups.
module rf_write_queue
  import rf_write_queue_pkg::*;
#(
  parameter int DEPTH  = RWQ_DEPTH,
  parameter int DATA_W = RWQ_DATA_W,
  parameter int REG_W  = RWQ_REG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_W-1:0]        in_regsel,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    drain_en,
  output logic [REG_W-1:0]        writeregsel,
  output logic [DATA_W-1:0]       writedata,
  output logic                    write,
  output logic [(1<<REG_W)-1:0]   pending,
  input  logic [REG_W-1:0]        look1sel,
  input  logic [REG_W-1:0]        look2sel,
  output logic                    look1hit,
  output logic                    look2hit,
  output logic [DATA_W-1:0]       look1data,
  output logic [DATA_W-1:0]       look2data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] data_q   [DEPTH];
  logic [DATA_W-1:0] data_d   [DEPTH];
  logic [REG_W-1:0]  regsel_q [DEPTH];
  logic [REG_W-1:0]  regsel_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  logic push;
  logic pop;

  logic [DEPTH*REG_W-1:0]  regsel_flat;
  logic [DEPTH*DATA_W-1:0] data_flat;

  // in_ready depends only on occupancy, so a same-cycle pop never frees a slot.
  assign in_ready = (count_q < FULL_CNT);
  assign write    = drain_en && (count_q != '0);
  assign push     = in_valid && in_ready;
  assign pop      = write;

  assign writeregsel = valid_q[head_q] ? regsel_q[head_q] : '0;
  assign writedata   = valid_q[head_q] ? data_q[head_q]   : '0;
  assign count       = count_q;
  assign err         = err_q;

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        pending[regsel_q[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    data_d   = data_q;
    regsel_d = regsel_q;
    valid_d  = valid_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    err_d    = in_valid && !in_ready;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    // A push while not full never lands on the head slot being popped.
    if (push) begin
      data_d[tail_q]   = in_data;
      regsel_d[tail_q] = in_regsel;
      valid_d[tail_q]  = 1'b1;
      tail_d           = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]   <= '0;
        regsel_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      data_q   <= data_d;
      regsel_q <= regsel_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    regsel_flat = '0;
    data_flat   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      regsel_flat[i*REG_W +: REG_W]  = regsel_q[i];
      data_flat[i*DATA_W +: DATA_W]  = data_q[i];
    end
  end

  rf_wq_lookup #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .REG_W (REG_W),
    .PTR_W (PTR_W)
  ) u_look1 (
    .valid      (valid_q),
    .regsel_flat(regsel_flat),
    .data_flat  (data_flat),
    .head       (head_q),
    .sel        (look1sel),
    .hit        (look1hit),
    .data       (look1data)
  );

  rf_wq_lookup #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .REG_W (REG_W),
    .PTR_W (PTR_W)
  ) u_look2 (
    .valid      (valid_q),
    .regsel_flat(regsel_flat),
    .data_flat  (data_flat),
    .head       (head_q),
    .sel        (look2sel),
    .hit        (look2hit),
    .data       (look2data)
  );

endmodule

// File: doc/rf_write_queue.md
Name: rf_write_queue

Overview:
- Write-side companion of the bypassing register file: buffers register writebacks from multi-cycle producers (loads, multi-cycle ALU ops) and retires one write per cycle into the register file's write port (writeregsel/writedata/write).
- Exposes per-register pending bits and two lookup ports so decode can forward queued-but-not-yet-written values or stall on them.
- Sits between the writeback stage and the rf_bypass write port.

Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2.
- DATA_W, 16, register data width.
- REG_W, 3, register select width (2**REG_W registers).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  producer has a write to enqueue.
- in_ready  out  1  queue can accept; high when count < DEPTH.
- in_regsel  in  REG_W  destination register of enqueued write.
- in_data  in  DATA_W  data of enqueued write.
- drain_en  in  1  allows head entry to retire this cycle.
- writeregsel  out  REG_W  to rf write port: head regsel.
- writedata  out  DATA_W  to rf write port: head data.
- write  out  1  to rf write port: retire strobe.
- pending  out  2**REG_W  bit r set if any valid entry targets register r.
- look1sel, look2sel  in  REG_W  decode read selects.
- look1hit, look2hit  out  1  matching valid entry exists.
- look1data, look2data  out  DATA_W  data of youngest matching entry.
- count  out  clog2(DEPTH)+1  occupancy.
- err  out  1  registered overflow flag.

Behaviour:
- Storage: circular buffer, head/tail pointers wrap modulo DEPTH, plus per-entry valid bit; count tracked explicitly (0..DEPTH).
- Reset (async, any time incl. mid-drain): all valid bits 0, head=tail=0, count=0, err=0. Outputs then: write=0, pending=0, look*hit=0, in_ready=1. writeregsel/writedata/look*data are 0 whenever no entry is valid/matching (never X).
- Push: in_valid && in_ready at clk edge writes tail entry, tail++, valid set.
- Pop: write = drain_en && count!=0 (combinational). writeregsel/writedata combinationally reflect head. Pop at the edge where write=1: head++, valid cleared.
- Latency: entry pushed at edge N can drive write no earlier than the cycle after edge N. No same-cycle pass-through.
- Ordering: strict FIFO. Multiple entries to the same register retire in program order.
- Simultaneous push+pop: both occur and count is unchanged. When full, in_ready=0 even if a pop occurs that cycle (in_ready depends on count only, no combinational path from drain_en).
- Overflow: in_valid && !in_ready at an edge sets err=1 for exactly the next cycle. The entry is dropped and state is unchanged. The producer must hold in_valid.
- pending: OR over valid entries of one-hot(regsel); combinational from current state. Entries popping this cycle still count.
- Lookup: among valid entries, select the youngest (closest to tail) with regsel==lookNsel.
  - hit=1 with its data; otherwise hit=0, data=0.
  - Combinational, same cycle. Does not include the in_* entry being pushed this cycle.
- Both lookups are independent and may select the same register.
- err only from overflow. Arithmetic: pointers REG-sized to clog2(DEPTH), count one bit wider. No saturation needed beyond the in_ready guard.

Decomposition:
- Shared package: DEPTH/DATA_W/REG_W defaults and the pointer-width constant.
- One natural sub-module: rf_wq_lookup, a combinational youngest-match priority selector over the entry array with head pointer. Instantiated twice (look1, look2).
- Storage, pointers and handshake live in the top.

Test Plan:
- Reset mid-operation: push R3=0x1111 and R5=0x2222, assert rst while drain_en=1 → same cycle write=0, pending=0x00, count=0, in_ready=1; after release look1sel=3 gives hit=0.
- Basic drain: drain_en=0, push R2=0xABCD; next cycle pending=0x04 and look1sel=2 gives hit=1, data=0xABCD. Raise drain_en → write=1, writeregsel=2, writedata=0xABCD for one cycle; then pending=0x00.
- Youngest forwarding: push R1=0x0001, R4=0x0044, R1=0x0101 (drain off) → look1sel=1 gives 0x0101, look2sel=4 gives 0x0044, pending=0x12. Drain one → R1 still pending with 0x0101.
- Full/overflow: push 4 entries, in_ready=0, count=4. Present 5th (R7=0xFFFF) → err=1 next cycle only, no R7 in pending. Pop one → in_ready=1 the next cycle; push retried and accepted.
- Simultaneous push/pop at count=2 with drain on for 6 cycles: count stays 2, writes emerge in exact push order, pointers wrap past DEPTH without loss.
- Drain stall: drain_en=0 with count=3 for 5 cycles → write=0, contents/pending stable. drain_en=1 → three consecutive write cycles in FIFO order.
